// File: rtl/axi4_burst_master_if.sv
// axi4_burst_master_if: AXI4 bus between the burst master and a memory-mapped slave
// Parameters: DATA_WIDTH (data bits), ADDR_WIDTH (byte-address bits)
// Channels: AW/W/B write, AR/R read; modport master drives the request side, slave the response side
interface axi4_burst_master_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic [7:0]              AWLEN;
    logic [2:0]              AWSIZE;
    logic [1:0]              AWBURST;
    logic                    AWVALID;
    logic                    AWREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WLAST;
    logic                    WVALID;
    logic                    WREADY;
    logic [1:0]              BRESP;
    logic                    BVALID;
    logic                    BREADY;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic [7:0]              ARLEN;
    logic [2:0]              ARSIZE;
    logic [1:0]              ARBURST;
    logic                    ARVALID;
    logic                    ARREADY;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic [1:0]              RRESP;
    logic                    RLAST;
    logic                    RVALID;
    logic                    RREADY;
    modport master (
        output AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, input AWREADY,
        output WDATA, WSTRB, WLAST, WVALID, input WREADY,
        input BRESP, BVALID, output BREADY,
        output ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, input ARREADY,
        input RDATA, RRESP, RLAST, RVALID, output RREADY
    );
    modport slave (
        input AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, output AWREADY,
        input WDATA, WSTRB, WLAST, WVALID, output WREADY,
        output BRESP, BVALID, input BREADY,
        input ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, output ARREADY,
        output RDATA, RRESP, RLAST, RVALID, input RREADY
    );
endinterface

// File: rtl/axi4_burst_master.sv
// axi4_burst_master: turns one command into a single AXI4 INCR burst, one command in flight
// Ports: ACLK/ARESETn (sync, active-low); cmd_* command handshake; wr_* write-beat push stream;
//        rd_* read-beat pop stream; done/done_resp one-cycle merged result; axi AXI4 master bus
module axi4_burst_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic [2:0]            cmd_size,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [1:0]            rd_resp,
    output logic                  rd_last,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  done,
    output logic [1:0]            done_resp,
    axi4_burst_master_if.master   axi
);
    localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_WIDTH/8));
    typedef enum logic [2:0] {IDLE, AW, W, B, AR, R, ERR} state_t;
    state_t state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0] len_q, len_d, cnt_q, cnt_d;
    logic [2:0] size_q, size_d;
    logic [1:0] resp_q, resp_d, done_resp_q, done_resp_d, r_max;
    logic last_err_q, last_err_d, done_q, done_d, illegal, last_beat, r_bad;
    logic [19:0] end_off;
    // Offset of the last beat inside its 4KB page; wide enough that no legal size overflows it
    assign end_off = 20'(cmd_addr[11:0]) + (20'(cmd_len) << cmd_size);
    assign illegal = (end_off > 20'hFFF) || (cmd_size > MAX_SIZE);
    assign axi.AWADDR = addr_q;
    assign axi.ARADDR = addr_q;
    assign axi.AWLEN = len_q;
    assign axi.ARLEN = len_q;
    assign axi.AWSIZE = size_q;
    assign axi.ARSIZE = size_q;
    assign axi.AWBURST = 2'b01;
    assign axi.ARBURST = 2'b01;
    assign axi.WDATA = wr_data;
    assign axi.WSTRB = '1;
    assign done = done_q;
    assign done_resp = done_resp_q;
    always_comb begin
        state_d = state_q;
        addr_d = addr_q;
        len_d = len_q;
        size_d = size_q;
        cnt_d = cnt_q;
        resp_d = resp_q;
        last_err_d = last_err_q;
        done_d = 1'b0;
        done_resp_d = done_resp_q;
        last_beat = cnt_q == 8'd0;
        r_max = (axi.RRESP > resp_q) ? axi.RRESP : resp_q;
        r_bad = last_err_q || (axi.RLAST != last_beat);
        // done_q blocks cmd_ready so a new command is only taken the cycle after done
        cmd_ready = ARESETn && state_q == IDLE && !done_q;
        axi.AWVALID = state_q == AW;
        axi.ARVALID = state_q == AR;
        axi.WVALID = state_q == W && wr_valid;
        axi.WLAST = state_q == W && last_beat;
        wr_ready = state_q == W && axi.WREADY;
        axi.BREADY = state_q == B;
        axi.RREADY = state_q == R && rd_ready;
        rd_valid = state_q == R && axi.RVALID;
        rd_data = state_q == R ? axi.RDATA : '0;
        rd_resp = state_q == R ? axi.RRESP : 2'b00;
        rd_last = state_q == R && axi.RLAST;
        case (state_q)
            IDLE: if (cmd_valid && cmd_ready) begin
                addr_d = cmd_addr;
                len_d = cmd_len;
                size_d = cmd_size;
                cnt_d = cmd_len;
                resp_d = 2'b00;
                last_err_d = 1'b0;
                done_d = illegal;
                done_resp_d = illegal ? 2'b10 : done_resp_q;
                state_d = illegal ? ERR : cmd_write ? AW : AR;
            end
            AW: state_d = axi.AWREADY ? W : AW;
            AR: state_d = axi.ARREADY ? R : AR;
            W: if (wr_valid && axi.WREADY) begin
                cnt_d = cnt_q - 8'd1;
                state_d = last_beat ? B : W;
            end
            B: if (axi.BVALID) begin
                done_d = 1'b1;
                done_resp_d = axi.BRESP;
                state_d = IDLE;
            end
            R: if (axi.RVALID && rd_ready) begin
                cnt_d = cnt_q - 8'd1;
                resp_d = r_max;
                last_err_d = r_bad;
                if (last_beat) begin
                    done_d = 1'b1;
                    done_resp_d = r_bad ? 2'b10 : r_max;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q <= IDLE;
            addr_q <= '0;
            len_q <= '0;
            size_q <= '0;
            cnt_q <= '0;
            resp_q <= '0;
            last_err_q <= 1'b0;
            done_q <= 1'b0;
            done_resp_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q <= addr_d;
            len_q <= len_d;
            size_q <= size_d;
            cnt_q <= cnt_d;
            resp_q <= resp_d;
            last_err_q <= last_err_d;
            done_q <= done_d;
            done_resp_q <= done_resp_d;
        end
    end
endmodule
